// File: rtl/otter_trap_pkg.sv
// otter_trap_pkg: shared constants and types for the OTTER machine-mode trap
// controller. Holds CSR addresses, the external-interrupt cause code, the
// implemented status/enable bit positions, PC-mux select encodings and the
// redirect FSM state type.
package otter_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MEIE_BIT = 11;

  localparam logic [2:0] PC_SEL_PLUS4 = 3'b000;
  localparam logic [2:0] PC_SEL_MTVEC = 3'b100;
  localparam logic [2:0] PC_SEL_MEPC  = 3'b101;

  typedef enum logic [1:0] {
    RUN,
    ENTER,
    RETURN
  } trap_state_t;

endpackage

// File: rtl/otter_trap_ctrl_intr_edge_latch.sv
// intr_edge_latch: detects a rising edge on the (already synchronised)
// external interrupt level and holds it as a pending request until a trap
// is taken.
//   clk, rst  : clock, synchronous active-high reset
//   intr      : interrupt level
//   clr       : trap taken this cycle, drop the pending request
//   pending   : registered pending flag (feeds mip.MEIP and the take logic)
module intr_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic intr,
  input  logic clr,
  output logic pending
);

  logic intr_prev;
  logic rise;

  assign rise = intr & ~intr_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      intr_prev <= 1'b0;
      pending   <= 1'b0;
    end else begin
      intr_prev <= intr;
      // A fresh edge landing on the same cycle as a take must not be lost.
      if (rise)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/otter_trap_ctrl.sv
// otter_trap_ctrl: machine-mode trap controller for the OTTER core.
// Holds mstatus (MIE/MPIE), mie (MEIE), mtvec, mepc, mcause and mip, decides
// at each instruction boundary whether to take the external interrupt or
// return from a trap, and drives a one-cycle PC-mux override.
//   CLK, RST        : clock, synchronous active-high reset
//   INTR            : external interrupt level (synchronised)
//   INSTR_DONE      : retire pulse, qualifies MRET_EXEC and CSR_WE
//   PC_NEXT         : next-instruction address, saved to mepc on a take
//   MRET_EXEC       : mret retiring
//   CSR_WE/ADDR/WD  : CSR write port; CSR_ADDR also selects CSR_RD
//   CSR_RD          : combinational CSR read, 0 for unimplemented addresses
//   MTVEC, MEPC     : register values to the PC mux
//   TRAP_SEL        : PC-mux select override (000 / 100 / 101)
//   TRAP_VALID      : TRAP_SEL is an override this cycle
//   INT_TAKEN       : pulse coincident with a trap-entry redirect
module otter_trap_ctrl
  import otter_trap_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        INTR,
  input  logic        INSTR_DONE,
  input  logic [31:0] PC_NEXT,
  input  logic        MRET_EXEC,
  input  logic        CSR_WE,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_WD,
  output logic [31:0] CSR_RD,
  output logic [31:0] MTVEC,
  output logic [31:0] MEPC,
  output logic [2:0]  TRAP_SEL,
  output logic        TRAP_VALID,
  output logic        INT_TAKEN
);

  trap_state_t state;

  logic        mie_r;
  logic        mpie_r;
  logic        meie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic        pending;

  logic done;
  logic take;
  logic mret;
  logic wr;

  // Boundaries are only honoured in RUN; the redirect cycles never carry one.
  assign done = INSTR_DONE & (state == RUN);
  assign take = done & pending & mie_r & meie_r & ~MRET_EXEC;
  assign mret = done & MRET_EXEC;
  assign wr   = done & CSR_WE;

  intr_edge_latch u_intr_edge_latch (
    .clk     (CLK),
    .rst     (RST),
    .intr    (INTR),
    .clr     (take),
    .pending (pending)
  );

  // CSR state. The take/mret updates come after the software write so that
  // they win on the MIE/MPIE fields and on mepc in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mie_r    <= 1'b0;
      mpie_r   <= 1'b0;
      meie_r   <= 1'b0;
      mtvec_r  <= '0;
      mepc_r   <= '0;
      mcause_r <= '0;
    end else begin
      if (wr) begin
        case (CSR_ADDR)
          CSR_MSTATUS: begin
            mie_r  <= CSR_WD[MIE_BIT];
            mpie_r <= CSR_WD[MPIE_BIT];
          end
          CSR_MIE:   meie_r  <= CSR_WD[MEIE_BIT];
          CSR_MTVEC: mtvec_r <= CSR_WD & ~32'h3;
          CSR_MEPC:  mepc_r  <= CSR_WD & ~32'h3;
          default: ;
        endcase
      end
      if (take) begin
        mepc_r   <= PC_NEXT & ~32'h3;
        mpie_r   <= mie_r;
        mie_r    <= 1'b0;
        mcause_r <= MCAUSE_MEI;
      end else if (mret) begin
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
      end
    end
  end

  // Redirect FSM with registered outputs: ENTER and RETURN each last one
  // cycle, giving a one-cycle redirect latency from the boundary edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      TRAP_SEL   <= PC_SEL_PLUS4;
      TRAP_VALID <= 1'b0;
      INT_TAKEN  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (take) begin
            state      <= ENTER;
            TRAP_SEL   <= PC_SEL_MTVEC;
            TRAP_VALID <= 1'b1;
            INT_TAKEN  <= 1'b1;
          end else if (mret) begin
            state      <= RETURN;
            TRAP_SEL   <= PC_SEL_MEPC;
            TRAP_VALID <= 1'b1;
            INT_TAKEN  <= 1'b0;
          end else begin
            state      <= RUN;
            TRAP_SEL   <= PC_SEL_PLUS4;
            TRAP_VALID <= 1'b0;
            INT_TAKEN  <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          TRAP_SEL   <= PC_SEL_PLUS4;
          TRAP_VALID <= 1'b0;
          INT_TAKEN  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    CSR_RD = '0;
    case (CSR_ADDR)
      CSR_MSTATUS: begin
        CSR_RD[MIE_BIT]  = mie_r;
        CSR_RD[MPIE_BIT] = mpie_r;
      end
      CSR_MIE:    CSR_RD[MEIE_BIT] = meie_r;
      CSR_MTVEC:  CSR_RD = mtvec_r;
      CSR_MEPC:   CSR_RD = mepc_r;
      CSR_MCAUSE: CSR_RD = mcause_r;
      CSR_MIP:    CSR_RD[MEIE_BIT] = pending;
      default:    CSR_RD = '0;
    endcase
  end

  assign MTVEC = mtvec_r;
  assign MEPC  = mepc_r;

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// Directed bench for otter_trap_ctrl: expected values are queued when the
// stimulus is applied and popped against DUT outputs one cycle later.
module tb_otter_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INTR;
  logic        INSTR_DONE;
  logic [31:0] PC_NEXT;
  logic        MRET_EXEC;
  logic        CSR_WE;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_WD;
  logic [31:0] CSR_RD;
  logic [31:0] MTVEC;
  logic [31:0] MEPC;
  logic [2:0]  TRAP_SEL;
  logic        TRAP_VALID;
  logic        INT_TAKEN;

  int vectors     = 0;
  int miscompares = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  otter_trap_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .INTR       (INTR),
    .INSTR_DONE (INSTR_DONE),
    .PC_NEXT    (PC_NEXT),
    .MRET_EXEC  (MRET_EXEC),
    .CSR_WE     (CSR_WE),
    .CSR_ADDR   (CSR_ADDR),
    .CSR_WD     (CSR_WD),
    .CSR_RD     (CSR_RD),
    .MTVEC      (MTVEC),
    .MEPC       (MEPC),
    .TRAP_SEL   (TRAP_SEL),
    .TRAP_VALID (TRAP_VALID),
    .INT_TAKEN  (INT_TAKEN)
  );

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic csr_read(input logic [11:0] a, input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    CSR_ADDR = a;
    #1;
    sb_check(CSR_RD);
  endtask

  task automatic outs(input string tag, input logic [2:0] sel, input logic vld, input logic tk);
    sb_push({tag, "_sel"}, {29'b0, sel});
    sb_push({tag, "_valid"}, {31'b0, vld});
    sb_push({tag, "_taken"}, {31'b0, tk});
    sb_check({29'b0, TRAP_SEL});
    sb_check({31'b0, TRAP_VALID});
    sb_check({31'b0, INT_TAKEN});
  endtask

  task automatic boundary(input logic mret, input logic we, input logic [11:0] a,
                          input logic [31:0] wd, input logic [31:0] pc);
    @(negedge CLK);
    INSTR_DONE = 1'b1;
    MRET_EXEC  = mret;
    CSR_WE     = we;
    CSR_ADDR   = a;
    CSR_WD     = wd;
    PC_NEXT    = pc;
    @(posedge CLK);
    #1;
    INSTR_DONE = 1'b0;
    MRET_EXEC  = 1'b0;
    CSR_WE     = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_intr(input logic v);
    @(negedge CLK);
    INTR = v;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; INTR = 1'b0; INSTR_DONE = 1'b0; PC_NEXT = '0;
    MRET_EXEC = 1'b0; CSR_WE = 1'b0; CSR_ADDR = '0; CSR_WD = '0;

    // Reset state
    tick();
    tick();
    outs("reset", 3'b000, 1'b0, 1'b0);
    sb_push("reset_mtvec", 32'h0); sb_check(MTVEC);
    sb_push("reset_mepc", 32'h0);  sb_check(MEPC);
    csr_read(12'h300, "reset_mstatus", 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // CSR writes with masking
    boundary(1'b0, 1'b1, 12'h305, 32'h0000_0103, 32'h4);
    csr_read(12'h305, "mtvec_rd", 32'h0000_0100);
    sb_push("mtvec_out", 32'h0000_0100); sb_check(MTVEC);
    outs("csr_wr", 3'b000, 1'b0, 1'b0);
    boundary(1'b0, 1'b1, 12'h304, 32'hFFFF_FFFF, 32'h8);
    csr_read(12'h304, "mie_rd", 32'h0000_0800);
    boundary(1'b0, 1'b1, 12'h300, 32'hFFFF_FFFF, 32'hC);
    csr_read(12'h300, "mstatus_mask", 32'h0000_0088);
    boundary(1'b0, 1'b1, 12'h300, 32'h0000_0008, 32'h10);
    csr_read(12'h300, "mstatus_mie", 32'h0000_0008);
    csr_read(12'h123, "unimpl_rd", 32'h0);

    // Interrupt taken at a boundary
    set_intr(1'b1);
    csr_read(12'h344, "mip_pending", 32'h0000_0800);
    boundary(1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0043);
    outs("take", 3'b100, 1'b1, 1'b1);
    sb_push("take_mepc", 32'h0000_0040); sb_check(MEPC);
    csr_read(12'h342, "take_mcause", 32'h8000_000B);
    csr_read(12'h300, "take_mstatus", 32'h0000_0080);
    csr_read(12'h344, "take_mip", 32'h0);
    tick();
    outs("enter_end", 3'b000, 1'b0, 1'b0);

    // mret back
    boundary(1'b1, 1'b0, 12'h000, 32'h0, 32'h0000_0100);
    outs("mret", 3'b101, 1'b1, 1'b0);
    sb_push("mret_mepc", 32'h0000_0040); sb_check(MEPC);
    csr_read(12'h300, "mret_mstatus", 32'h0000_0088);
    tick();
    outs("return_end", 3'b000, 1'b0, 1'b0);

    // Edge arrives while MIE = 0: stays pending until MIE is set
    boundary(1'b0, 1'b1, 12'h300, 32'h0, 32'h60);
    csr_read(12'h300, "mie_off", 32'h0);
    set_intr(1'b0);
    set_intr(1'b1);
    csr_read(12'h344, "mip_masked", 32'h0000_0800);
    boundary(1'b0, 1'b0, 12'h000, 32'h0, 32'h80);
    outs("masked", 3'b000, 1'b0, 1'b0);
    csr_read(12'h344, "mip_held", 32'h0000_0800);
    boundary(1'b0, 1'b1, 12'h300, 32'h0000_0008, 32'h80);
    outs("mie_set_bdry", 3'b000, 1'b0, 1'b0);
    boundary(1'b0, 1'b0, 12'h000, 32'h0, 32'h84);
    outs("late_take", 3'b100, 1'b1, 1'b1);
    sb_push("late_mepc", 32'h0000_0084); sb_check(MEPC);
    csr_read(12'h344, "late_mip", 32'h0);
    tick();
    boundary(1'b1, 1'b0, 12'h000, 32'h0, 32'h0);
    tick();
    csr_read(12'h300, "late_restore", 32'h0000_0088);

    // mstatus write and take on the same boundary: take wins
    set_intr(1'b0);
    set_intr(1'b1);
    boundary(1'b0, 1'b1, 12'h300, 32'h0000_0008, 32'h0000_0100);
    outs("wr_take", 3'b100, 1'b1, 1'b1);
    csr_read(12'h300, "wr_take_mstatus", 32'h0000_0080);
    sb_push("wr_take_mepc", 32'h0000_0100); sb_check(MEPC);
    tick();
    boundary(1'b1, 1'b0, 12'h000, 32'h0, 32'h0);
    tick();
    csr_read(12'h300, "wr_take_restore", 32'h0000_0088);

    // Reset during ENTER aborts the redirect
    set_intr(1'b0);
    set_intr(1'b1);
    boundary(1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0200);
    outs("pre_rst", 3'b100, 1'b1, 1'b1);
    RST = 1'b1;
    tick();
    outs("rst_enter", 3'b000, 1'b0, 1'b0);
    sb_push("rst_mepc", 32'h0); sb_check(MEPC);
    sb_push("rst_mtvec", 32'h0); sb_check(MTVEC);
    csr_read(12'h344, "rst_mip", 32'h0);
    INTR = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    outs("post_rst", 3'b000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otter_trap_ctrl.md
# otter_trap_ctrl

Machine-mode trap controller for the OTTER core: holds the trap CSRs (mstatus, mie, mtvec, mepc, mcause, mip), latches the external interrupt, and decides when the fetch stage takes a trap or returns from one. It drives the MTVEC and MEPC values and the trap-redirect select into the PC next-address multiplexer. The encodings it produces are 3'b100 for a trap (mtvec) and 3'b101 for a return (mepc). It sits beside the control unit and the CSR read path in the execute stage.

## Interface
- No parameters; all widths fixed (XLEN 32, CSR address 12).
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- INTR  in  1  external interrupt level, already synchronised to CLK
- INSTR_DONE  in  1  one-cycle pulse; current instruction retires and a trap may be taken at this boundary
- PC_NEXT  in  32  address of the next instruction to execute, valid with INSTR_DONE
- MRET_EXEC  in  1  mret retiring; qualified by INSTR_DONE
- CSR_WE  in  1  CSR write strobe; qualified by INSTR_DONE
- CSR_ADDR  in  12  CSR address for read and write
- CSR_WD  in  32  CSR write data
- CSR_RD  out  32  combinational read of CSR_ADDR; 0 for unimplemented addresses
- MTVEC  out  32  trap vector to the PC mux
- MEPC  out  32  return address to the PC mux
- TRAP_SEL  out  3  PC-mux select override: 3'b100 on trap entry, 3'b101 on return, otherwise 3'b000
- TRAP_VALID  out  1  TRAP_SEL is an override this cycle
- INT_TAKEN  out  1  one-cycle pulse coincident with a trap-entry redirect

## Operation
- CSRs and addresses:
  - mstatus 0x300: only MIE (bit 3) and MPIE (bit 7) are implemented; other bits read 0.
  - mie 0x304: only MEIE (bit 11) is implemented.
  - mtvec 0x305: bits [1:0] forced 0.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342: read-only to software.
  - mip 0x344: read-only; MEIP (bit 11) = pending.
- Pending latch: set on a rising edge of INTR (INTR high, previous sample low). Cleared when a trap is taken. If set and clear happen in the same cycle, set wins.
- Take condition: INSTR_DONE & pending & MIE & MEIE & ~MRET_EXEC.
- On take, registered at the edge:
  - mepc ← PC_NEXT & ~3
  - MPIE ← MIE; MIE ← 0
  - mcause ← 32'h8000_000B
  - FSM → ENTER
- On INSTR_DONE & MRET_EXEC: MIE ← MPIE; MPIE ← 1; FSM → RETURN.
- CSR write (CSR_WE & INSTR_DONE): updates the addressed register. In the same cycle, a take or mret overrides the MIE/MPIE fields of an mstatus write, and a take overrides an mepc write.
- FSM states:
  - RUN: TRAP_VALID = 0, TRAP_SEL = 000.
  - ENTER: exactly one cycle; TRAP_VALID = 1, TRAP_SEL = 100, INT_TAKEN = 1; then → RUN.
  - RETURN: exactly one cycle; TRAP_VALID = 1, TRAP_SEL = 101; then → RUN.
  - INSTR_DONE is ignored in ENTER and RETURN; the core guarantees none arrives there.

## Timing
- Redirect latency: one cycle. The take or mret boundary is at edge N; TRAP_SEL and TRAP_VALID are valid during cycle N+1, and the PC loads MTVEC or MEPC at edge N+1.
- MTVEC and MEPC outputs are the register values. A take at edge N makes the new mepc visible from cycle N+1.
- CSR_RD is combinational and reflects the register state before the current edge.
- An INTR edge that arrives while MIE = 0 stays pending and is taken at the first qualifying boundary after MIE is set.
- Reset:
  - All CSRs = 0, pending = 0, FSM = RUN.
  - TRAP_SEL = 000, TRAP_VALID = 0, INT_TAKEN = 0.
  - Reset in ENTER or RETURN aborts the redirect, with outputs 0 in the next cycle.

## Structure
- Package otter_trap_pkg holds:
  - CSR address constants
  - MCAUSE_MEI = 32'h8000_000B
  - bit indices MIE_BIT, MPIE_BIT, MEIE_BIT
  - PC_SEL_PLUS4 = 3'b000, PC_SEL_MTVEC = 3'b100, PC_SEL_MEPC = 3'b101
  - enum trap_state_t {RUN, ENTER, RETURN}
- Sub-module intr_edge_latch contains the INTR previous-sample register and the pending set/clear logic, with set-priority.

## Test plan
- Reset, then write mtvec = 0x0000_0103: CSR_RD for 0x305 = 0x0000_0100; all outputs 0 during reset.
- MIE = 1, MEIE = 1, INTR rises, INSTR_DONE with PC_NEXT = 0x40: next cycle TRAP_SEL = 100, TRAP_VALID = 1, INT_TAKEN = 1; mepc = 0x40, mcause = 0x8000_000B, MIE = 0, MPIE = 1, mip = 0.
- mret at boundary after a trap: next cycle TRAP_SEL = 101, MEPC = 0x40; then MIE = 1, MPIE = 1.
- INTR rises with MIE = 0: mip reads 0x800 and no redirect; writing mstatus = 0x8 then triggers a trap at the next INSTR_DONE.
- Same boundary carries an mstatus write of 0x8 and a take: MIE = 0 and MPIE = 1 afterward, because the take wins.
- RST asserted during ENTER: next cycle TRAP_VALID = 0, mepc = 0, pending = 0.
